rps_round_fsm: RTL

//  Game-round controller downstream of the SPI byte receiver. Consumes the per-byte gesture

---
 rtl/rps_round_if.sv | 28 ++
 rtl/rps_round_fsm.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rps_round_if.sv
// Rock-paper-scissors round controller bus.
// Master drives start/rx bytes, slave reports round state and scores.
interface rps_round_if #(
  parameter int SCORE_W = 4
);
  logic               start;
  logic               rx_valid;
  logic [7:0]         rx_byte;
  logic               busy;
  logic [1:0]         countdown;
  logic [2:0]         player_move;
  logic [2:0]         cpu_move;
  logic [1:0]         result;
  logic [SCORE_W-1:0] player_score;
  logic [SCORE_W-1:0] cpu_score;

  modport master (
    output start, rx_valid, rx_byte,
    input  busy, countdown, player_move, cpu_move,
    input  result, player_score, cpu_score
  );

  modport slave (
    input  start, rx_valid, rx_byte,
    output busy, countdown, player_move, cpu_move,
    output result, player_score, cpu_score
  );
endinterface

// File: rtl/rps_round_fsm.sv
// Rock-paper-scissors round controller: countdown, gesture
// capture with debounce, LFSR cpu move, saturating scores.
module rps_round_fsm #(
  parameter int COUNT_CYCLES   = 48_000_000,
  parameter int STABLE_N       = 4,
  parameter int TIMEOUT_CYCLES = 240_000_000,
  parameter int HOLD_CYCLES    = 96_000_000,
  parameter int SCORE_W        = 4
) (
  input logic       clk,
  input logic       reset,
  rps_round_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, COUNT, CAPTURE, RESULT
  } state_t;

  localparam logic [SCORE_W-1:0] SMAX = '1;

  state_t             state, state_n;
  logic [31:0]        timer, timer_n;
  logic [1:0]         cdown, cdown_n;
  logic [2:0]         cand, cand_n;
  logic [7:0]         stable, stable_n;
  logic [7:0]         lfsr, lfsr_n;
  logic [2:0]         pmove, pmove_n;
  logic [2:0]         cmove, cmove_n;
  logic [1:0]         res, res_n;
  logic [SCORE_W-1:0] pscore, pscore_n;
  logic [SCORE_W-1:0] cscore, cscore_n;

  logic [2:0] code;
  logic       code_ok;
  logic [1:0] pick;
  logic [2:0] pick_oh;
  logic [7:0] upd_stable;
  logic       lock;
  logic       beats;
  logic [1:0] outcome;
  logic       unused_bits;

  assign code       = bus.rx_byte[7:5];
  assign unused_bits = ^bus.rx_byte[4:0];
  assign code_ok    = (code == 3'b100) ||
                      (code == 3'b010) ||
                      (code == 3'b001);
  assign pick       = 2'(lfsr % 8'd3);
  assign upd_stable = (code == cand) ? stable + 8'd1 : 8'd1;
  assign lock       = bus.rx_valid && code_ok &&
                      (upd_stable == 8'(STABLE_N));

  // Decode the cpu pick and score the player's gesture against it
  always_comb begin
    pick_oh = 3'b000;
    unique case (1'b1)
      (pick == 2'd0): pick_oh = 3'b100;
      (pick == 2'd1): pick_oh = 3'b010;
      default:        pick_oh = 3'b001;
    endcase
    beats = (code == 3'b100 && pick_oh == 3'b001) ||
            (code == 3'b001 && pick_oh == 3'b010) ||
            (code == 3'b010 && pick_oh == 3'b100);
    outcome = (code == pick_oh) ? 2'b11 :
              beats             ? 2'b01 : 2'b10;
  end

  // Next-state and datapath updates for the round sequence
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    cdown_n  = cdown;
    cand_n   = cand;
    stable_n = stable;
    pmove_n  = pmove;
    cmove_n  = cmove;
    res_n    = res;
    pscore_n = pscore;
    cscore_n = cscore;
    lfsr_n   = {lfsr[6:0],
                lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = COUNT;
          cdown_n = 2'd3;
          timer_n = '0;
        end
      end
      COUNT: begin
        if (timer == 32'(COUNT_CYCLES - 1)) begin
          timer_n = '0;
          if (cdown == 2'd1) begin
            state_n  = CAPTURE;
            cdown_n  = 2'd0;
            cand_n   = '0;
            stable_n = '0;
            res_n    = 2'b00;
            pmove_n  = '0;
            cmove_n  = '0;
          end else begin
            cdown_n = cdown - 2'd1;
          end
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      CAPTURE: begin
        timer_n = timer + 32'd1;
        if (bus.rx_valid) begin
          if (code_ok) begin
            cand_n   = code;
            stable_n = upd_stable;
          end else begin
            cand_n   = '0;
            stable_n = '0;
          end
        end
        if (lock) begin
          state_n = RESULT;
          timer_n = '0;
          pmove_n = code;
          cmove_n = pick_oh;
          res_n   = outcome;
          if (outcome == 2'b01 && pscore != SMAX)
            pscore_n = pscore + SCORE_W'(1);
          if (outcome == 2'b10 && cscore != SMAX)
            cscore_n = cscore + SCORE_W'(1);
        end else if (timer == 32'(TIMEOUT_CYCLES - 1)) begin
          state_n = RESULT;
          timer_n = '0;
          pmove_n = '0;
          cmove_n = pick_oh;
          res_n   = 2'b10;
          if (cscore != SMAX)
            cscore_n = cscore + SCORE_W'(1);
        end
      end
      RESULT: begin
        if (timer == 32'(HOLD_CYCLES - 1)) begin
          state_n = IDLE;
          timer_n = '0;
        end else begin
          timer_n = timer + 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      timer  <= '0;
      cdown  <= '0;
      cand   <= '0;
      stable <= '0;
      lfsr   <= 8'h01;
      pmove  <= '0;
      cmove  <= '0;
      res    <= '0;
      pscore <= '0;
      cscore <= '0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      cdown  <= cdown_n;
      cand   <= cand_n;
      stable <= stable_n;
      lfsr   <= lfsr_n;
      pmove  <= pmove_n;
      cmove  <= cmove_n;
      res    <= res_n;
      pscore <= pscore_n;
      cscore <= cscore_n;
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.countdown    = cdown;
  assign bus.player_move  = pmove;
  assign bus.cpu_move     = cmove;
  assign bus.result       = res;
  assign bus.player_score = pscore;
  assign bus.cpu_score    = cscore;

endmodule
